// File: rtl/conv_win_ctrl.sv
// Frame sequencer for the 5x5 conv unit: holds weights/bias, walks a valid-mode
// 5x5 window over the frame, feeds conv and writes each result to the output RAM.
module conv_win_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int DW    = 9,
  parameter int IA_W  = 10,
  parameter int OA_W  = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_sel,
  input  logic [5*DW-1:0]   cfg_data,
  output logic [5*DW-1:0]   weight_m_1,
  output logic [5*DW-1:0]   weight_m_2,
  output logic [5*DW-1:0]   weight_m_3,
  output logic [5*DW-1:0]   weight_m_4,
  output logic [5*DW-1:0]   weight_m_5,
  output logic [DW-1:0]     bias,
  output logic              img_rd_en,
  output logic [IA_W-1:0]   img_rd_addr,
  input  logic [5*DW-1:0]   img_rd_data,
  output logic [5*DW-1:0]   x_m_1,
  output logic [5*DW-1:0]   x_m_2,
  output logic [5*DW-1:0]   x_m_3,
  output logic [5*DW-1:0]   x_m_4,
  output logic [5*DW-1:0]   x_m_5,
  output logic              x_valid,
  input  logic              conv_valid,
  input  logic [DW-1:0]     conv_data,
  output logic              out_we,
  output logic [OA_W-1:0]   out_addr,
  output logic [DW-1:0]     out_data
);

  localparam int RW = (IMG_H > 5) ? $clog2(IMG_H) : 3;
  localparam int CW = (IMG_W > 5) ? $clog2(IMG_W) : 3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_FIRE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        k;
  logic [RW-1:0]     r;
  logic [CW-1:0]     c;
  logic [OA_W-1:0]   oaddr;
  logic [DW-1:0]     res_q;
  logic [DW-1:0]     bias_q;
  logic [5*DW-1:0]   w_q [5];
  logic [5*DW-1:0]   x_q [5];
  logic              last_col, last_row, fetch_rd;

  assign last_col = (c == CW'(IMG_W - 5));
  assign last_row = (r == RW'(IMG_H - 5));
  assign fetch_rd = (state == S_FETCH) && (k != 3'd5);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: if (k == 3'd5) state_nxt = S_FIRE;
      S_FIRE:  state_nxt = S_WAIT;
      S_WAIT:  if (conv_valid) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (last_row && last_col) ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode; the read address is forced to zero outside fetch reads
  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    img_rd_en   = fetch_rd;
    img_rd_addr = '0;
    if (fetch_rd)
      img_rd_addr = (IA_W'(r) + IA_W'(k)) * IA_W'(IMG_W) + IA_W'(c);
    x_valid     = (state == S_FIRE);
    out_we      = (state == S_WRITE);
    out_addr    = oaddr;
    out_data    = res_q;
  end

  // Window position, fetch phase and output address
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k     <= '0;
      r     <= '0;
      c     <= '0;
      oaddr <= '0;
    end else begin
      k <= (state == S_FETCH && k != 3'd5) ? k + 3'd1 : 3'd0;
      if (state == S_IDLE && start) begin
        r     <= '0;
        c     <= '0;
        oaddr <= '0;
      end else if (state == S_WRITE) begin
        oaddr <= oaddr + OA_W'(1);
        if (last_col) begin
          c <= '0;
          r <= r + RW'(1);
        end else begin
          c <= c + CW'(1);
        end
      end
    end
  end

  // Window rows land one cycle after their read; result captured on conv_valid
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 5; i++) x_q[i] <= '0;
      res_q <= '0;
    end else begin
      if (state == S_FETCH) begin
        case (k)
          3'd1: x_q[0] <= img_rd_data;
          3'd2: x_q[1] <= img_rd_data;
          3'd3: x_q[2] <= img_rd_data;
          3'd4: x_q[3] <= img_rd_data;
          3'd5: x_q[4] <= img_rd_data;
          default: ;
        endcase
      end
      if (state == S_WAIT && conv_valid) res_q <= conv_data;
    end
  end

  // Configuration registers are writable only while idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 5; i++) w_q[i] <= '0;
      bias_q <= '0;
    end else if (state == S_IDLE && cfg_we) begin
      case (cfg_sel)
        3'd0: w_q[0] <= cfg_data;
        3'd1: w_q[1] <= cfg_data;
        3'd2: w_q[2] <= cfg_data;
        3'd3: w_q[3] <= cfg_data;
        3'd4: w_q[4] <= cfg_data;
        3'd5: bias_q <= cfg_data[DW-1:0];
        default: ;
      endcase
    end
  end

  assign weight_m_1 = w_q[0];
  assign weight_m_2 = w_q[1];
  assign weight_m_3 = w_q[2];
  assign weight_m_4 = w_q[3];
  assign weight_m_5 = w_q[4];
  assign bias       = bias_q;
  assign x_m_1      = x_q[0];
  assign x_m_2      = x_q[1];
  assign x_m_3      = x_q[2];
  assign x_m_4      = x_q[3];
  assign x_m_5      = x_q[4];

endmodule
